// File: rtl/uart_ctrl.sv
// Bus-mapped UART controller: TX/RX byte FIFOs, TX/RX handshake sequencers
// toward a UART core, sticky status flags and a 12-bit baud register.
module uart_ctrl #(
    parameter int          TX_DEPTH     = 4,
    parameter int          RX_DEPTH     = 2,
    parameter logic [11:0] DEFAULT_BAUD = 12'd104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [7:0]  bus_rdata,
    output logic        start_tx,
    output logic [7:0]  tx_value,
    input  logic        tx_done,
    input  logic        rx_available,
    input  logic [7:0]  rx_value,
    output logic        rx_clear,
    output logic [11:0] uart_baud_counter,
    output logic [1:0]  tx_state_dbg,
    output logic        rx_state_dbg
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_CNT_MAX = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_CNT_MAX = (RX_AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_SEND, T_REL} tx_state_e;
    typedef enum logic {R_WAIT, R_CLR} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]       tx_value_q, tx_value_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [11:0]      baud_q, baud_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             baud_rej_q, baud_rej_d;

    logic       rd_en, data_wr, status_wr, lo_wr, hi_wr, baud_ok;
    logic       tx_pop, tx_push_ok, rx_push, rx_pop;
    logic [7:0] status;

    // A simultaneous read and write performs only the write.
    assign rd_en     = bus_re && !bus_we;
    assign data_wr   = bus_we && (bus_addr == 2'd0);
    assign status_wr = bus_we && (bus_addr == 2'd1);
    assign lo_wr     = bus_we && (bus_addr == 2'd2);
    assign hi_wr     = bus_we && (bus_addr == 2'd3);
    assign baud_ok   = (tx_state_q == T_IDLE) && (tx_cnt_q == '0);

    assign status = {1'b0, baud_rej_q, tx_ovf_q, (rx_cnt_q == RX_CNT_MAX), (rx_cnt_q != '0),
                     (tx_state_q != T_IDLE), (tx_cnt_q == '0), (tx_cnt_q == TX_CNT_MAX)};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_value_d = tx_value_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            T_IDLE: if (tx_cnt_q != '0) begin
                tx_pop     = 1'b1;
                tx_value_d = tx_mem_q[tx_rd_q];
                tx_state_d = T_SEND;
            end
            T_SEND:  if (tx_done) tx_state_d = T_REL;
            T_REL:   if (!tx_done) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign tx_push_ok = data_wr && ((tx_cnt_q != TX_CNT_MAX) || tx_pop);

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push_ok) begin
            tx_mem_d[tx_wr_q] = bus_wdata;
            tx_wr_d           = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
        case ({tx_push_ok, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // A full RX FIFO leaves the core's byte uncleared, stalling the core.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            R_WAIT: if (rx_available && (rx_cnt_q != RX_CNT_MAX)) begin
                rx_push    = 1'b1;
                rx_state_d = R_CLR;
            end
            R_CLR:   if (!rx_available) rx_state_d = R_WAIT;
            default: rx_state_d = R_WAIT;
        endcase
    end

    assign rx_pop = rd_en && (bus_addr == 2'd0) && (rx_cnt_q != '0);

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_value;
            rx_wr_d           = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        baud_d     = baud_q;
        tx_ovf_d   = tx_ovf_q;
        baud_rej_d = baud_rej_q;
        rdata_d    = rdata_q;
        if (status_wr && bus_wdata[5]) tx_ovf_d = 1'b0;
        if (status_wr && bus_wdata[6]) baud_rej_d = 1'b0;
        if (data_wr && !tx_push_ok) tx_ovf_d = 1'b1;
        if (lo_wr || hi_wr) begin
            if (!baud_ok) baud_rej_d = 1'b1;
            else if (lo_wr) baud_d[7:0] = bus_wdata;
            else baud_d[11:8] = bus_wdata[3:0];
        end
        if (rd_en) begin
            case (bus_addr)
                2'd0:    rdata_d = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : 8'h00;
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = baud_q[7:0];
                default: rdata_d = {4'h0, baud_q[11:8]};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_WAIT;
            for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
            for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_value_q <= 8'h00;
            rdata_q    <= 8'h00;
            baud_q     <= DEFAULT_BAUD;
            tx_ovf_q   <= 1'b0;
            baud_rej_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_value_q <= tx_value_d;
            rdata_q    <= rdata_d;
            baud_q     <= baud_d;
            tx_ovf_q   <= tx_ovf_d;
            baud_rej_q <= baud_rej_d;
        end
    end

    assign start_tx          = (tx_state_q == T_SEND);
    assign rx_clear          = (rx_state_q == R_CLR);
    assign tx_value          = tx_value_q;
    assign bus_rdata         = rdata_q;
    assign uart_baud_counter = baud_q;
    assign tx_state_dbg      = tx_state_q;
    assign rx_state_dbg      = rx_state_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: the bench plays both the bus master and the
// UART core; inputs change and outputs are sampled on the falling clock edge.
module tb_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we, bus_re;
    logic [7:0]  bus_rdata;
    logic        start_tx;
    logic [7:0]  tx_value;
    logic        tx_done;
    logic        rx_available;
    logic [7:0]  rx_value;
    logic        rx_clear;
    logic [11:0] uart_baud_counter;
    logic [1:0]  tx_state_dbg;
    logic        rx_state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_ctrl #(.TX_DEPTH(4), .RX_DEPTH(2), .DEFAULT_BAUD(12'd104)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .start_tx(start_tx), .tx_value(tx_value), .tx_done(tx_done),
        .rx_available(rx_available), .rx_value(rx_value), .rx_clear(rx_clear),
        .uart_baud_counter(uart_baud_counter), .tx_state_dbg(tx_state_dbg),
        .rx_state_dbg(rx_state_dbg)
    );

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk); bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); bus_addr = a; bus_re = 1'b1;
        @(negedge clk); bus_re = 1'b0; d = bus_rdata;
    endtask

    task automatic wait_start(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (start_tx) break;
            @(negedge clk);
        end
        ok = start_tx;
    endtask

    // Core side of one received byte: present, wait for clear, release.
    task automatic rx_present(input logic [7:0] v, output bit ok);
        @(negedge clk); rx_available = 1'b1; rx_value = v;
        for (int i = 0; i < 20; i++) begin
            if (rx_clear) break;
            @(negedge clk);
        end
        ok = rx_clear;
        rx_available = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1; bus_addr = 2'd0; bus_wdata = 8'h00; bus_we = 1'b0; bus_re = 1'b0;
        tx_done = 1'b0; rx_available = 1'b0; rx_value = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (start_tx !== 1'b0) begin n_err++; $display("FAIL reset_start_tx: got %b want 0", start_tx); end
        n_cmp++; if (rx_clear !== 1'b0) begin n_err++; $display("FAIL reset_rx_clear: got %b want 0", rx_clear); end
        n_cmp++; if (tx_value !== 8'h00) begin n_err++; $display("FAIL reset_tx_value: got %02h want 00", tx_value); end
        n_cmp++; if (bus_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %02h want 00", bus_rdata); end
        n_cmp++; if (uart_baud_counter !== 12'd104) begin n_err++; $display("FAIL reset_baud: got %0d want 104", uart_baud_counter); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL reset_status: got %02h want 02", rd); end
        bus_read(2'd2, rd);
        n_cmp++; if (rd !== 8'h68) begin n_err++; $display("FAIL reset_baud_lo: got %02h want 68", rd); end
        bus_read(2'd3, rd);
        n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_baud_hi: got %02h want 00", rd); end
    endtask

    task automatic test_single_tx();
        logic [7:0] rd;
        bus_write(2'd0, 8'h55);
        n_cmp++; if (start_tx !== 1'b0) begin n_err++; $display("FAIL tx_n1_start: got %b want 0", start_tx); end
        @(negedge clk);
        n_cmp++; if (start_tx !== 1'b1) begin n_err++; $display("FAIL tx_n2_start: got %b want 1", start_tx); end
        n_cmp++; if (tx_value !== 8'h55) begin n_err++; $display("FAIL tx_value: got %02h want 55", tx_value); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h06) begin n_err++; $display("FAIL tx_status_send: got %02h want 06", rd); end
        tx_done = 1'b1;
        @(negedge clk);
        n_cmp++; if (start_tx !== 1'b0) begin n_err++; $display("FAIL tx_done_drop: got %b want 0", start_tx); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h06) begin n_err++; $display("FAIL tx_status_rel: got %02h want 06", rd); end
        tx_done = 1'b0;
        @(negedge clk);
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL tx_status_idle: got %02h want 02", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic [7:0] exp;
        bit ok;
        @(negedge clk); bus_addr = 2'd0; bus_we = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus_wdata = 8'(i);
            @(negedge clk);
        end
        bus_we = 1'b0;
        n_cmp++; if (start_tx !== 1'b1 || tx_value !== 8'h01) begin n_err++; $display("FAIL b2b_first: got start=%b val=%02h want 1/01", start_tx, tx_value); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h05) begin n_err++; $display("FAIL b2b_status_full: got %02h want 05", rd); end
        bus_write(2'd0, 8'h06);
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h25) begin n_err++; $display("FAIL b2b_overflow: got %02h want 25", rd); end
        bus_write(2'd1, 8'h20);
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h05) begin n_err++; $display("FAIL b2b_ovf_clear: got %02h want 05", rd); end
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            wait_start(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_start_timeout: got no start want start for %02h", exp); end
            n_cmp++; if (tx_value !== exp) begin n_err++; $display("FAIL b2b_order: got %02h want %02h", tx_value, exp); end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (start_tx !== 1'b0) begin n_err++; $display("FAIL b2b_dropped_sent: got %b want 0", start_tx); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL b2b_status_end: got %02h want 02", rd); end
    endtask

    task automatic test_rx();
        logic [7:0] rd;
        bit ok;
        int clr_seen;
        rx_present(8'hA1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rx_a1_clear: got no clear want clear"); end
        rx_present(8'hB2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rx_b2_clear: got no clear want clear"); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h1A) begin n_err++; $display("FAIL rx_status_full: got %02h want 1a", rd); end
        @(negedge clk); rx_available = 1'b1; rx_value = 8'hC3;
        clr_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rx_clear) clr_seen++;
        end
        n_cmp++; if (clr_seen !== 0) begin n_err++; $display("FAIL rx_full_backpressure: got %0d clear cycles want 0", clr_seen); end
        bus_read(2'd0, rd);
        n_cmp++; if (rd !== 8'hA1) begin n_err++; $display("FAIL rx_read_a1: got %02h want a1", rd); end
        for (int i = 0; i < 20; i++) begin
            if (rx_clear) break;
            @(negedge clk);
        end
        n_cmp++; if (rx_clear !== 1'b1) begin n_err++; $display("FAIL rx_c3_capture: got clear=%b want 1", rx_clear); end
        rx_available = 1'b0;
        @(negedge clk);
        n_cmp++; if (rx_clear !== 1'b0) begin n_err++; $display("FAIL rx_clear_release: got %b want 0", rx_clear); end
        bus_read(2'd0, rd);
        n_cmp++; if (rd !== 8'hB2) begin n_err++; $display("FAIL rx_read_b2: got %02h want b2", rd); end
        bus_read(2'd0, rd);
        n_cmp++; if (rd !== 8'hC3) begin n_err++; $display("FAIL rx_read_c3: got %02h want c3", rd); end
        bus_read(2'd0, rd);
        n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL rx_read_empty: got %02h want 00", rd); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL rx_status_end: got %02h want 02", rd); end
    endtask

    task automatic test_baud();
        logic [7:0] rd;
        bus_write(2'd0, 8'h77);
        @(negedge clk);
        n_cmp++; if (start_tx !== 1'b1) begin n_err++; $display("FAIL baud_send: got %b want 1", start_tx); end
        bus_write(2'd2, 8'h10);
        n_cmp++; if (uart_baud_counter !== 12'd104) begin n_err++; $display("FAIL baud_reject_kept: got %03h want 068", uart_baud_counter); end
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h46) begin n_err++; $display("FAIL baud_reject_flag: got %02h want 46", rd); end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        bus_write(2'd1, 8'h40);
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL baud_reject_clear: got %02h want 02", rd); end
        bus_write(2'd2, 8'h33);
        bus_write(2'd3, 8'h01);
        n_cmp++; if (uart_baud_counter !== 12'h133) begin n_err++; $display("FAIL baud_update: got %03h want 133", uart_baud_counter); end
        bus_read(2'd3, rd);
        n_cmp++; if (rd !== 8'h01) begin n_err++; $display("FAIL baud_hi_read: got %02h want 01", rd); end
        bus_read(2'd2, rd);
        n_cmp++; if (rd !== 8'h33) begin n_err++; $display("FAIL baud_lo_read: got %02h want 33", rd); end
        @(negedge clk); bus_addr = 2'd2; bus_wdata = 8'h44; bus_we = 1'b1; bus_re = 1'b1;
        @(negedge clk); bus_we = 1'b0; bus_re = 1'b0;
        n_cmp++; if (bus_rdata !== 8'h33) begin n_err++; $display("FAIL we_re_rdata_hold: got %02h want 33", bus_rdata); end
        n_cmp++; if (uart_baud_counter !== 12'h144) begin n_err++; $display("FAIL we_re_write: got %03h want 144", uart_baud_counter); end
        bus_write(2'd3, 8'hF2);
        n_cmp++; if (uart_baud_counter !== 12'h244) begin n_err++; $display("FAIL baud_hi_nibble: got %03h want 244", uart_baud_counter); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        int starts;
        @(negedge clk); bus_addr = 2'd0; bus_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_wdata = 8'hD1 + 8'(i);
            @(negedge clk);
        end
        bus_we = 1'b0;
        n_cmp++; if (start_tx !== 1'b1) begin n_err++; $display("FAIL rstmid_send: got %b want 1", start_tx); end
        rst = 1'b1;
        #1;
        n_cmp++; if (start_tx !== 1'b0) begin n_err++; $display("FAIL rstmid_start_async: got %b want 0", start_tx); end
        n_cmp++; if (tx_value !== 8'h00) begin n_err++; $display("FAIL rstmid_tx_value: got %02h want 00", tx_value); end
        n_cmp++; if (uart_baud_counter !== 12'd104) begin n_err++; $display("FAIL rstmid_baud: got %03h want 068", uart_baud_counter); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(2'd1, rd);
        n_cmp++; if (rd !== 8'h02) begin n_err++; $display("FAIL rstmid_status: got %02h want 02", rd); end
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (start_tx) starts++;
        end
        n_cmp++; if (starts !== 0) begin n_err++; $display("FAIL rstmid_discard: got %0d start cycles want 0", starts); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx();
        test_baud();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4: TX FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter RX_DEPTH, default 2: RX FIFO entries, power of two, 2..16.
REQ-003 SHALL have parameter DEFAULT_BAUD, default 12'd104: reset value of the baud register.
REQ-004 SHALL have clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have bus_addr  in  2  register select: 0 DATA, 1 STATUS, 2 BAUD_LO, 3 BAUD_HI.
REQ-007 SHALL have bus_wdata  in  8  write data.
REQ-008 SHALL have bus_we  in  1  single-cycle write strobe.
REQ-009 SHALL have bus_re  in  1  single-cycle read strobe.
REQ-010 SHALL have bus_rdata  out  8  registered read data.
REQ-011 SHALL have start_tx  out  1  and tx_value  out  8: transmit request and byte to the UART core.
REQ-012 SHALL have tx_done  in  1  UART core transmit-complete level.
REQ-013 SHALL have rx_available  in  1  and rx_value  in  8: received byte pending in the UART core.
REQ-014 SHALL have rx_clear  out  1  acknowledge/release of the core's received byte.
REQ-015 SHALL have uart_baud_counter  out  12  half-bit period count, driven from the baud register.

Function
REQ-016 DATA write SHALL push bus_wdata into the TX FIFO; a push is accepted if count < TX_DEPTH or a pop occurs in the same cycle, else the byte is dropped and STATUS[5] (tx_overflow, sticky) is set.
REQ-017 TX sequencer SHALL have states T_IDLE, T_SEND, T_REL; start_tx = 1 only in T_SEND.
REQ-018 T_IDLE with TX FIFO non-empty SHALL pop the head into tx_value and go to T_SEND next cycle.
REQ-019 T_SEND SHALL go to T_REL when tx_done = 1; T_REL SHALL go to T_IDLE when tx_done = 0.
REQ-020 DATA write into an empty FIFO with T_IDLE at cycle N SHALL give start_tx = 1 at cycle N+2.
REQ-021 RX sequencer SHALL have states R_WAIT, R_CLR; rx_clear = 1 only in R_CLR.
REQ-022 R_WAIT with rx_available = 1 and RX count < RX_DEPTH SHALL push rx_value into the RX FIFO and go to R_CLR; when the FIFO is full it SHALL remain in R_WAIT without clearing (no data loss; backpressure via the core).
REQ-023 R_CLR SHALL return to R_WAIT when rx_available = 0.
REQ-024 DATA read SHALL return the RX FIFO head and pop it; a read when empty SHALL return 8'h00 with no pop.
REQ-025 STATUS read SHALL return {1'b0, baud_reject, tx_overflow, rx_full, rx_nonempty, tx_busy (state != T_IDLE), tx_empty, tx_full}.
REQ-026 STATUS write SHALL clear bit 5 and/or bit 6 where bus_wdata has a 1; other bits are read-only.
REQ-027 BAUD_LO/BAUD_HI writes SHALL update baud[7:0]/baud[11:8] (BAUD_HI uses bus_wdata[3:0]; reads return upper bits 0) only when T_IDLE and TX FIFO empty; otherwise they are ignored and STATUS[6] (baud_reject, sticky) is set.
REQ-028 bus_rdata SHALL update one cycle after bus_re and hold its value otherwise.
REQ-029 bus_we and bus_re in the same cycle SHALL perform the write only; bus_rdata is unchanged.
REQ-030 TX and RX FIFO pointers SHALL wrap modulo depth; counts SHALL be log2(depth)+1 bits wide.

Reset
REQ-031 rst SHALL asynchronously force: FIFOs empty, T_IDLE, R_WAIT, start_tx = 0, rx_clear = 0, tx_value = 0, bus_rdata = 0, sticky bits = 0, baud = DEFAULT_BAUD.
REQ-032 rst asserted mid-transfer SHALL discard all queued and in-flight bytes; the UART core is reset from the same source.

Verification
REQ-033 Reset, read STATUS -> 8'h02; uart_baud_counter = 104.
REQ-034 Write DATA 0x55 at N -> start_tx = 1 at N+2, tx_value = 0x55; core pulses tx_done -> start_tx = 0 one cycle later; STATUS[2] clears after tx_done falls.
REQ-035 Write 5 bytes back-to-back while idle -> first pops at once, remaining 4 queued, no overflow; a 6th write before any drain -> STATUS[5] = 1; write STATUS 0x20 -> STATUS[5] = 0.
REQ-036 Core presents 0xA1, 0xB2, 0xC3 with no reads -> first two captured (STATUS[4] = 1), third not cleared (rx_clear stays 0); read DATA -> 0xA1, then 0xC3 captured.
REQ-037 BAUD_LO write 0x10 while T_SEND -> baud unchanged, STATUS[6] = 1; when idle, write BAUD_LO 0x33 and BAUD_HI 0x01 -> uart_baud_counter = 12'h133.
REQ-038 Assert rst while T_SEND with 3 bytes queued -> start_tx = 0 immediately, STATUS = 8'h02 after release.
